// File: rtl/mem_check_pkg.sv
// Shared types and helpers for the memory sweep checker.
// Holds the sweep FSM states, the latency ceiling and the saturating counter step.
package mem_check_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sweep_state_e;

  localparam int unsigned MAX_READ_LATENCY = 4;

  // Returns cnt + 1, holding at the all-ones value of a bits-wide counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned bits);
    logic [31:0] max_val;
    max_val = (32'd1 << bits) - 32'd1;
    return (cnt == max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with a valid bit.
// Keeps sideband data aligned with a memory's read latency.
module pipe_delay #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_data  = data_q[Depth-1];

endmodule

// File: rtl/mem_sweep_checker.sv
// Sweeps a window of data memory and checks it against exp_first + i*exp_step.
// Reports pass/fail, a saturating error count and the first failing location.
module mem_sweep_checker
  import mem_check_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned ADDR_BITS    = 6,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
  input  logic [N-1:0]         exp_first,
  input  logic [N-1:0]         exp_step,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [N-1:0]         mem_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_BITS-1:0]  err_count,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic [N-1:0]         first_err_data
);

  localparam int unsigned PipeW     = ADDR_BITS + N;
  localparam int unsigned DrainBits = $clog2(MAX_READ_LATENCY);

  sweep_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [N-1:0]          exp_q, exp_d;
  logic [N-1:0]          step_q, step_d;
  logic [ADDR_BITS:0]    remain_q, remain_d;
  logic [DrainBits-1:0]  drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_BITS-1:0]   err_q, err_d;
  logic [ADDR_BITS-1:0]  ferr_addr_q, ferr_addr_d;
  logic [N-1:0]          ferr_data_q, ferr_data_d;

  logic                  chk_valid;
  logic [PipeW-1:0]      chk_data;
  logic [ADDR_BITS-1:0]  chk_addr;
  logic [N-1:0]          chk_exp;
  logic                  mismatch;

  assign mem_rd_en = (state_q == StIssue);
  assign mem_addr  = addr_q;

  // Address and expected value ride alongside the read so they meet mem_rd_data.
  pipe_delay #(
    .Width(PipeW),
    .Depth(READ_LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (mem_rd_en),
    .in_data  ({addr_q, exp_q}),
    .out_valid(chk_valid),
    .out_data (chk_data)
  );

  assign {chk_addr, chk_exp} = chk_data;
  assign mismatch = chk_valid && (mem_rd_data != chk_exp);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    exp_d       = exp_q;
    step_d      = step_q;
    remain_d    = remain_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;

    if (mismatch) begin
      err_d = CNT_BITS'(sat_inc(32'(err_q), CNT_BITS));
      // A non-zero count means the first failure is already recorded.
      if (err_q == '0) begin
        ferr_addr_d = chk_addr;
        ferr_data_d = mem_rd_data;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr;
          exp_d       = exp_first;
          step_d      = exp_step;
          remain_d    = length;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = (length == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        addr_d   = addr_q + ADDR_BITS'(1);
        exp_d    = exp_q + step_q;
        remain_d = remain_q - (ADDR_BITS+1)'(1);
        if (remain_q == (ADDR_BITS+1)'(1)) begin
          state_d = StDrain;
          drain_d = DrainBits'(READ_LATENCY - 1);
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - DrainBits'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      exp_q       <= '0;
      step_q      <= '0;
      remain_q    <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      exp_q       <= exp_d;
      step_q      <= step_d;
      remain_q    <= remain_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Bench for mem_sweep_checker: two instances (latency 1 / 8-bit count, latency 3 / 2-bit count)
// share one memory image and are checked every cycle against a transaction-level model.
module tb_mem_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] length;
  logic [7:0] exp_first;
  logic [7:0] exp_step;

  logic       rd_en0, rd_en1, busy0, busy1, done0, done1, pass0, pass1;
  logic [5:0] addr0, addr1, fa0, fa1;
  logic [7:0] rd_data0, rd_data1, fd0, fd1, err0;
  logic [1:0] err1;

  logic [7:0] mem [64];
  logic [7:0] rdp0 [1];
  logic [7:0] rdp1 [3];

  int n_assert = 0;
  int n_fail   = 0;

  mem_sweep_checker #(
    .N(8), .ADDR_BITS(6), .READ_LATENCY(1), .CNT_BITS(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .exp_first(exp_first), .exp_step(exp_step), .mem_rd_en(rd_en0), .mem_addr(addr0),
    .mem_rd_data(rd_data0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_addr(fa0), .first_err_data(fd0)
  );

  mem_sweep_checker #(
    .N(8), .ADDR_BITS(6), .READ_LATENCY(3), .CNT_BITS(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .exp_first(exp_first), .exp_step(exp_step), .mem_rd_en(rd_en1), .mem_addr(addr1),
    .mem_rd_data(rd_data1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_addr(fa1), .first_err_data(fd1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory read ports; non-strobed cycles return junk so misaligned compares show up.
  always @(posedge clk) begin
    rdp0[0] <= rd_en0 ? mem[addr0] : 8'($urandom);
    rdp1[0] <= rd_en1 ? mem[addr1] : 8'($urandom);
    rdp1[1] <= rdp1[0];
    rdp1[2] <= rdp1[1];
  end
  assign rd_data0 = rdp0[0];
  assign rd_data1 = rdp1[2];

  task automatic chk(input string name, input int actual, input int expected);
    n_assert++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: on an accepted start the whole sweep outcome is computed.
  int rl [2]   = '{1, 3};
  int cmax [2] = '{255, 3};
  int cyc = 0;
  bit act [2];
  int st_cyc [2], m_len [2], m_base [2], done_o [2];
  int fin_pass [2], fin_err [2], fin_fa [2], fin_fd [2];

  task automatic model_accept(input int d, input int at);
    int cnt, fa, fd, a, e;
    bit found;
    cnt = 0; fa = 0; fd = 0; found = 0;
    m_len[d]  = int'(length);
    m_base[d] = int'(base_addr);
    for (int i = 0; i < m_len[d]; i++) begin
      a = (m_base[d] + i) % 64;
      e = (int'(exp_first) + i * int'(exp_step)) % 256;
      if (int'(mem[a]) != e) begin
        if (!found) begin
          fa = a; fd = int'(mem[a]); found = 1;
        end
        cnt++;
      end
    end
    act[d]      = 1;
    st_cyc[d]   = at;
    done_o[d]   = (m_len[d] == 0) ? 1 : m_len[d] + rl[d] + 1;
    fin_err[d]  = (cnt > cmax[d]) ? cmax[d] : cnt;
    fin_pass[d] = (cnt == 0) ? 1 : 0;
    fin_fa[d]   = fa;
    fin_fd[d]   = fd;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; st_cyc[d] = 0; m_len[d] = 0; m_base[d] = 0; done_o[d] = 0;
      fin_pass[d] = 0; fin_err[d] = 0; fin_fa[d] = 0; fin_fd[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          act[d] = 0;
          fin_pass[d] = 0; fin_err[d] = 0; fin_fa[d] = 0; fin_fd[d] = 0;
        end else if (start && !(act[d] && (cyc - st_cyc[d]) < done_o[d])) begin
          model_accept(d, cyc + 1);
        end
      end
      cyc++;
    end
  end

  task automatic check_dut(input int d, input logic b, input logic dn, input logic re,
                           input int ad, input logic p, input int er, input int fa,
                           input int fd);
    int o;
    o = cyc - st_cyc[d];
    if (act[d] && o < done_o[d]) begin
      chk($sformatf("d%0d busy", d), b, 1);
      chk($sformatf("d%0d done", d), dn, 0);
      chk($sformatf("d%0d rd_en", d), re, (o < m_len[d]) ? 1 : 0);
      if (o < m_len[d]) chk($sformatf("d%0d mem_addr", d), ad, (m_base[d] + o) % 64);
    end else begin
      chk($sformatf("d%0d busy", d), b, 0);
      chk($sformatf("d%0d done", d), dn, (act[d] && o == done_o[d]) ? 1 : 0);
      chk($sformatf("d%0d rd_en", d), re, 0);
      chk($sformatf("d%0d pass", d), p, fin_pass[d]);
      chk($sformatf("d%0d err_count", d), er, fin_err[d]);
      chk($sformatf("d%0d first_err_addr", d), fa, fin_fa[d]);
      chk($sformatf("d%0d first_err_data", d), fd, fin_fd[d]);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check_dut(0, busy0, done0, rd_en0, int'(addr0), pass0, int'(err0), int'(fa0), int'(fd0));
      check_dut(1, busy1, done1, rd_en1, int'(addr1), pass1, int'(err1), int'(fa1), int'(fd1));
    end
  end

  int lat0, lat1, nd0, nd1, nrd0;

  // Runs one sweep; mid >= 0 pulses start again at that cycle offset while busy.
  task automatic sweep(input int b, input int l, input int f, input int s, input int mid);
    bit ended;
    @(negedge clk);
    base_addr = 6'(b); length = 7'(l); exp_first = 8'(f); exp_step = 8'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = 6'($urandom); length = 7'($urandom_range(64, 0));
    exp_first = 8'($urandom); exp_step = 8'($urandom);
    lat0 = -1; lat1 = -1; nd0 = 0; nd1 = 0; nrd0 = 0; ended = 0;
    for (int o = 0; o < 300; o++) begin
      if (done0) begin nd0++; if (lat0 < 0) lat0 = o; end
      if (done1) begin nd1++; if (lat1 < 0) lat1 = o; end
      if (rd_en0) nrd0++;
      if (!busy0 && !busy1) begin
        ended = 1;
        break;
      end
      start = (o == mid);
      @(negedge clk);
    end
    start = 1'b0;
    chk("sweep ends within bound", ended, 1);
  endtask

  initial begin
    int b, l, f, s, mid, a;
    rst_n = 1'b0; start = 1'b0;
    base_addr = '0; length = '0; exp_first = '0; exp_step = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset pass", pass0, 0);
    chk("reset err_count", err0, 0);
    chk("reset mem_rd_en", rd_en0, 0);
    chk("reset mem_addr", addr0, 0);
    rst_n = 1'b1;

    // Matching ramp 2..7 at address 0.
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 2);
    sweep(0, 6, 2, 1, -1);
    chk("ramp done latency", lat0, 8);
    chk("ramp pass", pass0, 1);
    chk("ramp err_count", err0, 0);
    chk("ramp done pulses", nd0, 1);

    // One bad word.
    mem[3] = 8'd9;
    sweep(0, 6, 2, 1, -1);
    chk("bad word pass", pass0, 0);
    chk("bad word err_count", err0, 1);
    chk("bad word first_err_addr", fa0, 3);
    chk("bad word first_err_data", fd0, 9);

    // Address and expected value both wrap.
    mem[62] = 8'd250; mem[63] = 8'd253; mem[0] = 8'd0; mem[1] = 8'd3;
    sweep(62, 4, 250, 3, -1);
    chk("wrap latency lat3", lat1, 8);
    chk("wrap latency lat1", lat0, 6);
    chk("wrap pass lat3", pass1, 1);

    // Empty window, with a start pulse during the busy cycle.
    sweep(0, 0, 0, 0, 0);
    chk("empty latency", lat0, 1);
    chk("empty latency lat3", lat1, 1);
    chk("empty pass", pass0, 1);
    chk("empty reads", nrd0, 0);
    chk("empty done pulses", nd0, 1);

    // Full window, every word wrong; also a start pulse mid-sweep.
    for (int i = 0; i < 64; i++) mem[(5 + i) % 64] = 8'(7 + 2 * i + 1);
    sweep(5, 64, 7, 2, 10);
    chk("full reads", nrd0, 64);
    chk("full err_count 8-bit", err0, 64);
    chk("full err_count saturated", err1, 3);
    chk("full first_err_addr", fa1, 5);
    chk("full done pulses", nd1, 1);

    // Reset during the third issue cycle.
    @(negedge clk);
    base_addr = 6'd20; length = 7'd10; exp_first = 8'd0; exp_step = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy0, 0);
    chk("abort done", done0, 0);
    chk("abort mem_rd_en", rd_en1, 0);
    chk("abort mem_addr", addr0, 0);
    chk("abort pass", pass1, 0);
    chk("abort err_count", err1, 0);
    chk("abort first_err_addr", fa0, 0);
    chk("abort first_err_data", fd0, 0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no done after abort", done1, 0);
    end
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 2);
    sweep(0, 6, 2, 1, -1);
    chk("post-abort latency", lat0, 8);
    chk("post-abort pass", pass0, 1);

    // Randomised windows with sparse corruption.
    for (int t = 0; t < 24; t++) begin
      b = $urandom_range(63, 0);
      l = $urandom_range(64, 0);
      f = $urandom_range(255, 0);
      s = $urandom_range(255, 0);
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < l; i++) begin
        a = (b + i) % 64;
        mem[a] = 8'(f + i * s);
        if ($urandom_range(5, 0) == 0) mem[a] = mem[a] ^ 8'($urandom_range(255, 1));
      end
      mid = -1;
      if ($urandom_range(1, 0) == 1) mid = (l == 0) ? 0 : $urandom_range(l + 1, 0);
      sweep(b, l, f, s, mid);
      chk("random done pulses", nd0 + nd1, 2);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
